// File: rtl/biriscv_issue_hazard.sv
// Issue-side hazard detection, operand forwarding, divide/CSR serialisation
// and a saturating hazard-stall counter.
module biriscv_issue_hazard #(
    parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
    parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        dec_valid_i,
    input  logic [4:0]  dec_ra_idx_i,
    input  logic [4:0]  dec_rb_idx_i,
    input  logic        dec_ra_used_i,
    input  logic        dec_rb_used_i,
    input  logic [4:0]  dec_rd_idx_i,
    input  logic        dec_rd_valid_i,
    input  logic        dec_div_i,
    input  logic        dec_csr_i,
    input  logic [31:0] rf_ra_value_i,
    input  logic [31:0] rf_rb_value_i,

    input  logic        pipe_stall_i,
    input  logic        squash_i,

    input  logic [4:0]  rd_e1_i,
    input  logic        load_e1_i,
    input  logic        mul_e1_i,
    input  logic        div_e1_i,
    input  logic        csr_e1_i,
    input  logic [31:0] alu_result_e1_i,

    input  logic [4:0]  rd_e2_i,
    input  logic        load_e2_i,
    input  logic        mul_e2_i,
    input  logic [31:0] result_e2_i,

    input  logic [4:0]  rd_wb_i,
    input  logic [31:0] result_wb_i,
    input  logic        csr_wb_i,
    input  logic        div_complete_i,

    output logic        issue_accept_o,
    output logic [31:0] operand_ra_o,
    output logic [31:0] operand_rb_o,
    output logic        div_pending_o,
    output logic [31:0] hazard_cycles_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_CSR_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [REG_W-1:0]   div_rd_q;
    logic [REG_W-1:0]   div_rd_d;
    logic [XLEN-1:0]    hazard_cnt_q;

    logic               e1_no_bypass;
    logic               e2_no_bypass;
    logic               div_block;
    logic               ra_hazard;
    logic               rb_hazard;
    logic               hazard;
    logic               structural;
    logic               launch_div;
    logic               launch_csr;

    // A source stalls on unforwardable producers or the outstanding divide
    function automatic logic src_hazard(input logic used, input logic [REG_W-1:0] idx,
                                        input logic [REG_W-1:0] e1_rd, input logic e1_nb,
                                        input logic [REG_W-1:0] e2_rd, input logic e2_nb,
                                        input logic div_blk, input logic [REG_W-1:0] div_rd);
        logic hit;
        hit = ((idx == e1_rd) && e1_nb) ||
              ((idx == e2_rd) && e2_nb) ||
              (div_blk && (idx == div_rd));
        return used && (idx != REG_W'(0)) && hit;
    endfunction

    // Forwarding mux: youngest producer wins, x0 always reads zero
    function automatic logic [XLEN-1:0] fwd(input logic [REG_W-1:0] idx,
                                            input logic [XLEN-1:0] rf_val);
        logic [XLEN-1:0] v;
        if (idx == REG_W'(0))         v = '0;
        else if (idx == rd_e1_i)      v = alu_result_e1_i;
        else if (idx == rd_e2_i)      v = result_e2_i;
        else if (idx == rd_wb_i)      v = result_wb_i;
        else                          v = rf_val;
        return v;
    endfunction

    // Hazard, structural stall and issue decision
    always_comb begin
        e1_no_bypass = load_e1_i | mul_e1_i | div_e1_i | csr_e1_i;
        e2_no_bypass = (load_e2_i & ~SUPPORT_LOAD_BYPASS) | (mul_e2_i & ~SUPPORT_MUL_BYPASS);
        // Completion clears the divide block in the same cycle
        div_block    = (state_q == ST_DIV_WAIT) & ~div_complete_i;

        ra_hazard = src_hazard(dec_ra_used_i, dec_ra_idx_i, rd_e1_i, e1_no_bypass,
                               rd_e2_i, e2_no_bypass, div_block, div_rd_q);
        rb_hazard = src_hazard(dec_rb_used_i, dec_rb_idx_i, rd_e1_i, e1_no_bypass,
                               rd_e2_i, e2_no_bypass, div_block, div_rd_q);
        hazard    = ra_hazard | rb_hazard;

        structural = (state_q == ST_CSR_WAIT) ||
                     (div_block && (dec_div_i ||
                                    (dec_rd_valid_i && (dec_rd_idx_i == div_rd_q))));

        issue_accept_o = rst_i & dec_valid_i & ~pipe_stall_i & ~squash_i &
                         ~hazard & ~structural;

        launch_div = issue_accept_o & dec_div_i & dec_rd_valid_i;
        launch_csr = issue_accept_o & dec_csr_i;

        operand_ra_o = fwd(dec_ra_idx_i, rf_ra_value_i);
        operand_rb_o = fwd(dec_rb_idx_i, rf_rb_value_i);
    end

    // Next-state logic; a new divide launch wins over a completion
    always_comb begin
        state_d  = state_q;
        div_rd_d = div_rd_q;
        case (state_q)
            ST_RUN: begin
                if (launch_div) begin
                    state_d  = ST_DIV_WAIT;
                    div_rd_d = dec_rd_idx_i;
                end else if (launch_csr) begin
                    state_d  = ST_CSR_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (div_complete_i) begin
                    if (launch_div) begin
                        state_d  = ST_DIV_WAIT;
                        div_rd_d = dec_rd_idx_i;
                    end else if (launch_csr) begin
                        state_d  = ST_CSR_WAIT;
                        div_rd_d = '0;
                    end else begin
                        state_d  = ST_RUN;
                        div_rd_d = '0;
                    end
                end
            end
            ST_CSR_WAIT: begin
                if (!pipe_stall_i && (csr_wb_i || squash_i)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                div_rd_d = '0;
            end
        endcase
    end

    // State and outstanding-divide destination registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_RUN;
            div_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            div_rd_q <= div_rd_d;
        end
    end

    // Saturating count of cycles lost to hazards or structural stalls
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hazard_cnt_q <= '0;
        end else if (dec_valid_i && !pipe_stall_i && !squash_i && (hazard || structural)
                     && (hazard_cnt_q != {XLEN{1'b1}})) begin
            hazard_cnt_q <= hazard_cnt_q + XLEN'(1);
        end
    end

    assign div_pending_o   = (state_q == ST_DIV_WAIT);
    assign hazard_cycles_o = hazard_cnt_q;

endmodule

// File: tb/tb_biriscv_issue_hazard.sv
// Scoreboard bench for biriscv_issue_hazard: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_biriscv_issue_hazard;

    localparam logic [31:0] RF_A   = 32'hAAAA_0001;
    localparam logic [31:0] RF_B   = 32'hBBBB_0002;
    localparam logic [31:0] ALU_E1 = 32'h0000_1234;
    localparam logic [31:0] RES_E2 = 32'hE2E2_E2E2;
    localparam logic [31:0] RES_WB = 32'h57B0_057B;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic [4:0]  dec_ra_idx_i, dec_rb_idx_i, dec_rd_idx_i;
    logic        dec_ra_used_i, dec_rb_used_i, dec_rd_valid_i;
    logic        dec_div_i, dec_csr_i;
    logic [31:0] rf_ra_value_i, rf_rb_value_i;
    logic        pipe_stall_i, squash_i;
    logic [4:0]  rd_e1_i, rd_e2_i, rd_wb_i;
    logic        load_e1_i, mul_e1_i, div_e1_i, csr_e1_i;
    logic [31:0] alu_result_e1_i, result_e2_i, result_wb_i;
    logic        load_e2_i, mul_e2_i;
    logic        csr_wb_i, div_complete_i;
    logic        issue_accept_o;
    logic [31:0] operand_ra_o, operand_rb_o;
    logic        div_pending_o;
    logic [31:0] hazard_cycles_o;

    biriscv_issue_hazard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_ra_idx_i(dec_ra_idx_i), .dec_rb_idx_i(dec_rb_idx_i),
        .dec_ra_used_i(dec_ra_used_i), .dec_rb_used_i(dec_rb_used_i),
        .dec_rd_idx_i(dec_rd_idx_i), .dec_rd_valid_i(dec_rd_valid_i),
        .dec_div_i(dec_div_i), .dec_csr_i(dec_csr_i),
        .rf_ra_value_i(rf_ra_value_i), .rf_rb_value_i(rf_rb_value_i),
        .pipe_stall_i(pipe_stall_i), .squash_i(squash_i),
        .rd_e1_i(rd_e1_i), .load_e1_i(load_e1_i), .mul_e1_i(mul_e1_i),
        .div_e1_i(div_e1_i), .csr_e1_i(csr_e1_i), .alu_result_e1_i(alu_result_e1_i),
        .rd_e2_i(rd_e2_i), .load_e2_i(load_e2_i), .mul_e2_i(mul_e2_i),
        .result_e2_i(result_e2_i),
        .rd_wb_i(rd_wb_i), .result_wb_i(result_wb_i), .csr_wb_i(csr_wb_i),
        .div_complete_i(div_complete_i),
        .issue_accept_o(issue_accept_o), .operand_ra_o(operand_ra_o),
        .operand_rb_o(operand_rb_o), .div_pending_o(div_pending_o),
        .hazard_cycles_o(hazard_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        acc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        pend;
        logic [31:0] hz;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (issue_accept_o !== e.acc) begin
                    errors++;
                    $display("FAIL %s accept: got %0b want %0b", e.name, issue_accept_o, e.acc);
                end
                checks++;
                if (operand_ra_o !== e.ra) begin
                    errors++;
                    $display("FAIL %s operand_ra: got %08h want %08h", e.name, operand_ra_o, e.ra);
                end
                checks++;
                if (operand_rb_o !== e.rb) begin
                    errors++;
                    $display("FAIL %s operand_rb: got %08h want %08h", e.name, operand_rb_o, e.rb);
                end
                checks++;
                if (div_pending_o !== e.pend) begin
                    errors++;
                    $display("FAIL %s div_pending: got %0b want %0b", e.name, div_pending_o, e.pend);
                end
                checks++;
                if (hazard_cycles_o !== e.hz) begin
                    errors++;
                    $display("FAIL %s hazard_cycles: got %0d want %0d", e.name, hazard_cycles_o, e.hz);
                end
            end
        end
    end

    // Return every per-cycle input to its idle value
    task automatic clr();
        dec_valid_i = 0; dec_ra_idx_i = 0; dec_rb_idx_i = 0; dec_rd_idx_i = 0;
        dec_ra_used_i = 0; dec_rb_used_i = 0; dec_rd_valid_i = 0;
        dec_div_i = 0; dec_csr_i = 0; pipe_stall_i = 0; squash_i = 0;
        rd_e1_i = 0; load_e1_i = 0; mul_e1_i = 0; div_e1_i = 0; csr_e1_i = 0;
        rd_e2_i = 0; load_e2_i = 0; mul_e2_i = 0; rd_wb_i = 0;
        csr_wb_i = 0; div_complete_i = 0;
    endtask

    // Decoded instruction with ra source and optional destination
    task automatic instr(input logic [4:0] ra, input logic [4:0] rd, input logic rdv);
        dec_valid_i = 1; dec_ra_idx_i = ra; dec_ra_used_i = 1;
        dec_rd_idx_i = rd; dec_rd_valid_i = rdv;
    endtask

    // Queue the expectation for the inputs just applied, then advance one cycle
    task automatic step(input string n, input logic acc, input logic [31:0] ra,
                        input logic [31:0] rb, input logic pend, input logic [31:0] hz);
        exp_t e;
        e.name = n; e.acc = acc; e.ra = ra; e.rb = rb; e.pend = pend; e.hz = hz;
        exp_q.push_back(e);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rf_ra_value_i = RF_A; rf_rb_value_i = RF_B;
        alu_result_e1_i = ALU_E1; result_e2_i = RES_E2; result_wb_i = RES_WB;
        clr();
        rst_i = 0;

        // Reset: accept held low even with a clean instruction
        instr(5'd1, 5'd8, 1); step("reset", 0, RF_A, 0, 0, 0);
        rst_i = 1;

        // ALU producer in E1 forwards
        clr(); rd_e1_i = 5; instr(5'd5, 5'd8, 1); step("alu_e1_fwd", 1, ALU_E1, 0, 0, 0);

        // Load in E1 stalls, then bypasses from E2
        clr(); rd_e1_i = 6; load_e1_i = 1; instr(5'd6, 5'd8, 1); step("load_e1_stall", 0, ALU_E1, 0, 0, 0);
        clr(); rd_e2_i = 6; load_e2_i = 1; instr(5'd6, 5'd8, 1); step("load_e2_bypass", 1, RES_E2, 0, 0, 1);

        // Divide x7, consumer stalls ten cycles, then issues on completion
        clr(); instr(5'd1, 5'd7, 1); dec_div_i = 1; step("div_x7_issue", 1, RF_A, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            clr(); instr(5'd7, 5'd9, 1); step("div_consumer_stall", 0, RF_A, 0, 1, 32'(1 + k));
        end
        clr(); instr(5'd7, 5'd9, 1); div_complete_i = 1; rd_wb_i = 7;
        step("div_complete_issue", 1, RES_WB, 0, 1, 11);
        clr(); step("div_back_to_run", 0, 0, 0, 0, 11);

        // New divide issued in the completion cycle reloads the destination
        clr(); instr(5'd0, 5'd10, 1); dec_div_i = 1; step("div_x10_issue", 1, 0, 0, 0, 11);
        clr(); instr(5'd0, 5'd12, 1); dec_div_i = 1; div_complete_i = 1;
        step("div_x12_on_complete", 1, 0, 0, 1, 11);
        clr(); instr(5'd12, 5'd9, 1); step("x12_consumer_stall", 0, RF_A, 0, 1, 11);
        clr(); instr(5'd10, 5'd9, 1); step("x10_now_free", 1, RF_A, 0, 1, 12);
        clr(); instr(5'd0, 5'd12, 1); step("waw_x12_stall", 0, 0, 0, 1, 12);
        clr(); div_complete_i = 1; step("div_x12_complete", 0, 0, 0, 1, 13);
        clr(); step("idle_run", 0, 0, 0, 0, 13);

        // CSR serialisation released by writeback
        clr(); instr(5'd0, 5'd3, 1); dec_csr_i = 1; step("csr_issue", 1, 0, 0, 0, 13);
        clr(); instr(5'd1, 5'd9, 1); step("csr_wait_1", 0, RF_A, 0, 0, 13);
        clr(); instr(5'd1, 5'd9, 1); step("csr_wait_2", 0, RF_A, 0, 0, 14);
        clr(); instr(5'd1, 5'd9, 1); csr_wb_i = 1; step("csr_wb_cycle", 0, RF_A, 0, 0, 15);
        clr(); instr(5'd1, 5'd9, 1); step("csr_released", 1, RF_A, 0, 0, 16);

        // CSR serialisation released by squash
        clr(); instr(5'd0, 5'd3, 1); dec_csr_i = 1; step("csr2_issue", 1, 0, 0, 0, 16);
        clr(); instr(5'd1, 5'd9, 1); squash_i = 1; step("csr2_squash", 0, RF_A, 0, 0, 16);
        clr(); instr(5'd1, 5'd9, 1); step("after_squash", 1, RF_A, 0, 0, 16);

        // Forwarding priority E1 > E2 > WB on both operands
        clr(); instr(5'd4, 5'd9, 1); dec_rb_idx_i = 4; dec_rb_used_i = 1;
        rd_e1_i = 4; rd_e2_i = 4; rd_wb_i = 4; step("prio_e1", 1, ALU_E1, ALU_E1, 0, 16);
        clr(); instr(5'd4, 5'd9, 1); dec_rb_idx_i = 4; dec_rb_used_i = 1;
        rd_e2_i = 4; rd_wb_i = 4; step("prio_e2", 1, RES_E2, RES_E2, 0, 16);
        clr(); instr(5'd4, 5'd9, 1); dec_rb_idx_i = 4; dec_rb_used_i = 1;
        rd_wb_i = 4; step("prio_wb", 1, RES_WB, RES_WB, 0, 16);
        clr(); instr(5'd1, 5'd9, 1); dec_rb_idx_i = 2; dec_rb_used_i = 1;
        step("rf_both", 1, RF_A, RF_B, 0, 16);

        // x0 as destination everywhere: reads zero, never stalls
        clr(); instr(5'd0, 5'd0, 1); dec_rb_used_i = 1;
        rd_e1_i = 0; load_e1_i = 1; mul_e1_i = 1; rd_e2_i = 0; mul_e2_i = 1;
        step("x0_read", 1, 0, 0, 0, 16);

        // Pipeline stall blocks issue without counting
        clr(); rd_e1_i = 6; load_e1_i = 1; instr(5'd6, 5'd9, 1); pipe_stall_i = 1;
        step("pipe_stall", 0, ALU_E1, 0, 0, 16);
        clr(); step("pipe_stall_no_count", 0, 0, 0, 0, 16);

        // Asynchronous reset in the middle of DIV_WAIT
        clr(); instr(5'd0, 5'd7, 1); dec_div_i = 1; step("div_x7_again", 1, 0, 0, 0, 16);
        clr(); instr(5'd7, 5'd9, 1); step("pre_reset_stall", 0, RF_A, 0, 1, 16);
        clr(); instr(5'd7, 5'd9, 1); rst_i = 0; step("async_reset", 0, RF_A, 0, 0, 0);
        rst_i = 1;
        clr(); instr(5'd7, 5'd9, 1); step("after_reset_run", 1, RF_A, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        clr();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biriscv_issue_hazard.md
Name: biriscv_issue_hazard

Overview:
- Issue-side hazard and operand-forwarding unit, directly upstream of the execute pipeline controller.
- Decides each cycle whether the decoded instruction may issue, and supplies its forwarded rs1/rs2 values.
- Tracks the out-of-pipe divide destination and serialises CSR instructions until they commit at writeback.
- Keeps a saturating hazard-stall counter for performance debug.

Parameters:
- SUPPORT_LOAD_BYPASS, 1: 1 = load/store result in E2 is forwardable via result_e2_i; 0 = a consumer of a load in E2 stalls.
- SUPPORT_MUL_BYPASS, 1: same rule for multiply results in E2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- dec_valid_i  in  1  decoded instruction present
- dec_ra_idx_i / dec_rb_idx_i  in  5  source register indices
- dec_ra_used_i / dec_rb_used_i  in  1  source actually read
- dec_rd_idx_i  in  5  destination register index
- dec_rd_valid_i  in  1  destination written
- dec_div_i / dec_csr_i  in  1  instruction class
- rf_ra_value_i / rf_rb_value_i  in  32  register-file read data
- pipe_stall_i  in  1  execute pipeline stall
- squash_i  in  1  pipeline flush (E1/E2 or WB squash)
- rd_e1_i  in  5  E1 destination; 0 = none
- load_e1_i / mul_e1_i / div_e1_i / csr_e1_i  in  1  E1 class
- alu_result_e1_i  in  32  E1 ALU result
- rd_e2_i  in  5  E2 destination
- load_e2_i / mul_e2_i  in  1  E2 class
- result_e2_i  in  32  E2 result (bypassed)
- rd_wb_i  in  5  WB destination
- result_wb_i  in  32  WB result
- csr_wb_i  in  1  CSR instruction committing
- div_complete_i  in  1  divider result written
- issue_accept_o  out  1  instruction issues this cycle
- operand_ra_o / operand_rb_o  out  32  forwarded operands
- div_pending_o  out  1  divide outstanding
- hazard_cycles_o  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM goes to RUN, div_rd_q = 0, hazard_cycles_o = 0.
  - issue_accept_o = 0 while reset is asserted.
- FSM states and transitions:
  - RUN → DIV_WAIT on an accepted divide with rd_valid.
  - RUN → CSR_WAIT on an accepted CSR instruction.
  - DIV_WAIT → RUN on div_complete_i.
  - CSR_WAIT → RUN on csr_wb_i or squash_i.
  - A divide without rd_valid (rd = x0) stays in RUN.
- Hazard (combinational). Source s is hazardous if used, idx != 0, and any of the following holds:
  - idx == rd_e1_i and (load_e1_i | mul_e1_i | div_e1_i | csr_e1_i);
  - idx == rd_e2_i and ((load_e2_i & !SUPPORT_LOAD_BYPASS) | (mul_e2_i & !SUPPORT_MUL_BYPASS));
  - state == DIV_WAIT and idx == div_rd_q.
- Structural stall:
  - state == CSR_WAIT;
  - state == DIV_WAIT and (dec_div_i, or dec_rd_valid_i with dec_rd_idx_i == div_rd_q) (WAW).
- issue_accept_o = dec_valid_i & ~pipe_stall_i & ~squash_i & ~hazard & ~structural.
- Forwarding priority, for each operand independently:
  1. idx == 0 → 0.
  2. E1 match → alu_result_e1_i.
  3. E2 match → result_e2_i.
  4. WB match → result_wb_i.
  5. Otherwise rf value.
- Simultaneous events:
  - div_complete_i in the same cycle as an accepted new divide: state returns to DIV_WAIT, and div_rd_q loads the new rd (set wins over clear).
  - div_complete_i removes the DIV_WAIT hazard in the same cycle (combinational clear), so a dependent may issue that cycle with rf/WB data.
  - squash_i does not clear DIV_WAIT; the divider still completes.
- hazard_cycles_o:
  - Increments when dec_valid_i & ~pipe_stall_i & ~squash_i & (hazard | structural).
  - Saturates at 0xFFFFFFFF.
- When pipe_stall_i is high, state and div_rd_q hold, except that div_complete_i is still honoured.

Test Plan:
- ALU producer x5 in E1; consumer reads x5 → accept=1, operand_ra_o = alu_result_e1_i (e.g. 0x1234).
- Load x6 in E1; add reads x6 → accept=0 for 1 cycle, hazard_cycles_o = 1. Next cycle, load in E2 (bypass=1) → accept=1, operand = result_e2_i.
- div x7 accepted → DIV_WAIT, div_pending_o = 1. Consumer of x7 stalls 10 cycles. On div_complete_i, accept=1 and FSM returns to RUN. Second div issued in the same cycle as the completion → DIV_WAIT with div_rd_q = new rd.
- CSR accepted → every following instruction stalls until csr_wb_i, then accept=1. squash_i during CSR_WAIT → RUN the next cycle.
- Reading x0 while x0 is listed as a destination anywhere → operand 0, no stall.
- rst_i low asserted mid-DIV_WAIT → asynchronous return to RUN, counter = 0, accept = 0.
